// File: rtl/tft_timing_ctrl_if.sv
// TFT raster bus: renderer coordinates/colour plus panel pins.
// Latency: none, signal bundle only.
// Backpressure: none; the raster is free-running and the renderer must keep pace.
interface tft_timing_ctrl_if;
  logic [23:0] rgb_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic        tft_de;
  logic [23:0] tft_rgb;
  logic        tft_bl;
  logic        frame_start;

  // Timing controller side: issues coordinates and panel pins, takes colour back.
  modport master (
    input  rgb_data,
    output pix_x, pix_y, hsync, vsync, tft_de, tft_rgb, tft_bl, frame_start
  );

  // Renderer/panel side.
  modport slave (
    output rgb_data,
    input  pix_x, pix_y, hsync, vsync, tft_de, tft_rgb, tft_bl, frame_start
  );
endinterface

// File: rtl/tft_timing_ctrl.sv
// TFT raster timing generator: h/v counters, syncs, DE, early pixel coordinates, RGB gating.
// Latency: syncs/DE/coords/frame_start one cycle after counters; tft_rgb combinational from rgb_data.
// Backpressure: none; free-running raster, renderer must deliver colour DATA_LAT cycles after coords.
module tft_timing_ctrl #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int DATA_LAT = 1
) (
  input  logic              tft_clk_9m,
  input  logic              sys_rst_n,
  tft_timing_ctrl_if.master tft
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;

  // Elaboration guards: 10-bit counters, and the request window must stay inside its own line.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("tft_timing_ctrl: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("tft_timing_ctrl: V_TOTAL exceeds 1024");
  end
  if (DATA_LAT < 0 || DATA_LAT > 2) begin : g_bad_lat
    $error("tft_timing_ctrl: DATA_LAT must be 0..2");
  end
  if (HA0 < DATA_LAT) begin : g_bad_wrap
    $error("tft_timing_ctrl: request window would wrap into previous line");
  end

  // Window edges are compared in 11 bits so an end edge of exactly 1024 stays representable.
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_END    = 11'(H_SYNC);
  localparam logic [10:0] VS_END    = 11'(V_SYNC);
  localparam logic [10:0] H_DE_BEG  = 11'(HA0);
  localparam logic [10:0] H_DE_END  = 11'(HA0 + H_ACTIVE);
  localparam logic [10:0] H_RQ_BEG  = 11'(HA0 - DATA_LAT);
  localparam logic [10:0] H_RQ_END  = 11'(HA0 + H_ACTIVE - DATA_LAT);
  localparam logic [10:0] V_DE_BEG  = 11'(VA0);
  localparam logic [10:0] V_DE_END  = 11'(VA0 + V_ACTIVE);
  localparam logic [9:0]  X_OFFSET  = 10'(HA0 - DATA_LAT);
  localparam logic [9:0]  Y_OFFSET  = 10'(VA0);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_vis;
  logic        v_vis;
  logic        h_req;

  logic        hsync_q;
  logic        vsync_q;
  logic        de_q;
  logic        bl_q;
  logic        fs_q;
  logic [9:0]  pix_x_q;
  logic [9:0]  pix_y_q;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign h_vis = (h_ext >= H_DE_BEG) && (h_ext < H_DE_END);
  assign v_vis = (v_ext >= V_DE_BEG) && (v_ext < V_DE_END);
  assign h_req = (h_ext >= H_RQ_BEG) && (h_ext < H_RQ_END);

  // Raster position: h wraps every line, v steps on the h wrap and wraps with it at frame end.
  always_ff @(posedge tft_clk_9m) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Registered outputs decoded from the current position; coordinates lead DE by DATA_LAT.
  always_ff @(posedge tft_clk_9m) begin
    if (!sys_rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      bl_q    <= 1'b0;
      fs_q    <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      hsync_q <= (h_ext >= HS_END);
      vsync_q <= (v_ext >= VS_END);
      de_q    <= h_vis && v_vis;
      bl_q    <= 1'b1;
      fs_q    <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      pix_x_q <= (h_req && v_vis) ? (h_cnt - X_OFFSET) : '0;
      pix_y_q <= (h_req && v_vis) ? (v_cnt - Y_OFFSET) : '0;
    end
  end

  assign tft.hsync       = hsync_q;
  assign tft.vsync       = vsync_q;
  assign tft.tft_de      = de_q;
  assign tft.tft_bl      = bl_q;
  assign tft.frame_start = fs_q;
  assign tft.pix_x       = pix_x_q;
  assign tft.pix_y       = pix_y_q;
  // Colour passes straight through in the DE cycle and is blanked elsewhere.
  assign tft.tft_rgb     = tft.rgb_data & {24{de_q}};

endmodule

// File: doc/tft_timing_ctrl.md
Name: tft_timing_ctrl

Overview:
- Raster timing generator and output stage for the TFT panel.
- Produces pixel coordinates (pix_x, pix_y) plus hsync/vsync for the pixel-rendering blocks (start screen, game field) to consume.
- Accepts their registered rgb_data back and drives the panel RGB/DE/sync pins.
- Pixel coordinates are issued DATA_LAT cycles ahead of tft_de, so a renderer with registered output lands exactly on the active pixel.

Parameters:
- H_SYNC, 41, hsync pulse width in clocks.
- H_BACK, 2, horizontal back porch.
- H_ACTIVE, 480, visible pixels per line.
- H_FRONT, 2, horizontal front porch.
- V_SYNC, 10, vsync pulse width in lines.
- V_BACK, 2, vertical back porch.
- V_ACTIVE, 272, visible lines.
- V_FRONT, 2, vertical front porch.
- DATA_LAT, 1, renderer latency from pix_x/pix_y to rgb_data; legal 0..2.

Ports:
- tft_clk_9m, in, 1, pixel clock, 9 MHz.
- sys_rst_n, in, 1, synchronous active-low reset.
- rgb_data, in, 24, pixel colour from renderer, {R,G,B}.
- pix_x, out, 10, requested pixel X; 0 outside request window.
- pix_y, out, 10, requested pixel Y; 0 outside request window.
- hsync, out, 1, line sync, low during sync pulse.
- vsync, out, 1, frame sync, low during sync pulse.
- tft_de, out, 1, data enable, high on visible pixels.
- tft_rgb, out, 24, panel RGB; equals rgb_data when tft_de=1, else 0.
- tft_bl, out, 1, backlight enable.
- frame_start, out, 1, one-cycle pulse at start of each frame.

Behaviour:
- Single clock domain: tft_clk_9m.
- Reset is synchronous and active-low via sys_rst_n. The clock and reset are named as above.
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (default 525).
  - V_TOTAL = sum of the V_* parameters (default 286).
  - HA0 = H_SYNC + H_BACK.
  - VA0 = V_SYNC + V_BACK.
- Internal counters h_cnt and v_cnt, 10 bits each. Totals must be ≤ 1024; this is checked by elaboration assertion.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0 at the same edge h_cnt wraps to 0.
- Output registering: every output except tft_rgb is registered from the current counter values, so all registered outputs lag the counters uniformly by 1 cycle.
- Output functions (registered, evaluated on the current h_cnt/v_cnt):
  - hsync = (h_cnt ≥ H_SYNC).
  - vsync = (v_cnt ≥ V_SYNC).
  - tft_de = HA0 ≤ h_cnt < HA0 + H_ACTIVE and VA0 ≤ v_cnt < VA0 + V_ACTIVE.
  - Request window: HA0 − DATA_LAT ≤ h_cnt < HA0 + H_ACTIVE − DATA_LAT, with v_cnt in the active range.
    - Inside the window: pix_x = h_cnt − (HA0 − DATA_LAT) and pix_y = v_cnt − VA0.
    - Outside the window: pix_x = 0 and pix_y = 0.
  - frame_start = (h_cnt == 0 && v_cnt == 0).
- tft_rgb is combinational: rgb_data & {24{tft_de}}. It adds no latency.
- Alignment guarantee: the cycle with pix_x = N is followed, DATA_LAT cycles later, by the tft_de cycle of column N. The last column's request (pix_x = H_ACTIVE−1) occurs exactly DATA_LAT cycles before tft_de falls.
- Line-boundary wrap: when DATA_LAT > 0 and HA0 < DATA_LAT, the request window must not wrap into the previous line. This is an elaboration error (HA0 ≥ DATA_LAT is required).
- Reset values, while sys_rst_n = 0 at a clock edge:
  - h_cnt = 0, v_cnt = 0.
  - hsync = 1, vsync = 1.
  - tft_de = 0, pix_x = 0, pix_y = 0.
  - frame_start = 0, tft_bl = 0.
- After reset release:
  - First edge: counters advance to h_cnt = 1. Outputs show values for h_cnt = 0, so hsync = 0, vsync = 0, frame_start = 1.
  - tft_bl goes to 1 on the first edge after release and stays 1.
- Reset mid-frame: the next edge forces all reset values, regardless of position. Any partial line is abandoned, and no frame_start is produced until the counters restart.
- No other state: there is no handshake with the renderer. The renderer must hold rgb_data valid in the tft_de cycle per the DATA_LAT contract.

Test Plan:
- Reset hold 5 cycles, then release → hsync = 0, vsync = 0, frame_start = 1 one cycle after release. hsync rises 41 cycles later. tft_bl = 1 from the first post-release cycle.
- Free-run 2 frames (defaults):
  - frame_start pulses exactly 150150 cycles apart.
  - hsync period 525 with low width 41.
  - vsync low for 10×525 = 5250 cycles.
  - tft_de high 480 cycles per line on exactly 272 lines per frame.
- Coordinate sweep, DATA_LAT = 1:
  - pix_x runs 0..479 starting 1 cycle before tft_de rises and ends 1 cycle before tft_de falls.
  - pix_y = 0 on the first active line and 271 on the last.
  - pix_x and pix_y are 0 everywhere outside the window.
- Data path, renderer model = 1-cycle register of {pix_y[7:0], 6'b0, pix_x}:
  - tft_rgb in the tft_de cycle of column 5, line 3 equals 24'h030005.
  - tft_rgb = 0 whenever tft_de = 0, even with rgb_data = 24'hFFFFFF.
- DATA_LAT = 0 and DATA_LAT = 2 builds: the pix_x = 0 request leads tft_de rise by 0 and 2 cycles respectively. A 2-stage renderer model passes the same colour-check as above.
- Assert sys_rst_n low for 1 cycle mid-line (line 100, column 200) → all outputs return to their reset values. The frame restarts with frame_start 1 cycle after release. The next full frame timing matches the free-run check.
